// File: rtl/ifetch_pq_if.sv
// Fetch-unit bus: downstream control in, instruction memory port, and presented instruction out.
// master = the fetch unit, slave = its environment (pipeline + memory).
interface ifetch_pq_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 9
);
  logic                stall;
  logic                redirect;
  logic [XLEN-1:0]     redirect_pc;
  logic                issue_nop;
  logic                imem_req;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [XLEN-1:0]     imem_rdata;
  logic [XLEN-1:0]     pc_out;
  logic [XLEN-1:0]     instruction;
  logic                valid;

  modport master (
    input  stall, redirect, redirect_pc, issue_nop, imem_rdata,
    output imem_req, imem_addr, pc_out, instruction, valid
  );

  modport slave (
    output stall, redirect, redirect_pc, issue_nop, imem_rdata,
    input  imem_req, imem_addr, pc_out, instruction, valid
  );
endinterface

// File: rtl/ifetch_pq.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue in front of a one-cycle-latency memory.
// Redirects flush the queue and squash the single outstanding response.
module ifetch_pq #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 9,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h00000013)
) (
  input  logic         clk,
  input  logic         reset,
  ifetch_pq_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
  logic              kill_q, kill_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;

  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [XLEN-1:0]   insn_mem [DEPTH];

  logic run, redir, req, push, pop, not_empty;
  logic [PW+1:0] occupancy;

  always_comb begin
    run       = (state_q == RUN);
    redir     = run && bus.redirect;
    not_empty = (count_q != '0);
    // Outstanding request counts against capacity so its response always has a slot.
    occupancy = {1'b0, count_q} + (PW+2)'(inflight_q);
    req       = run && (occupancy < DEPTH_W) && !bus.redirect;
    push      = inflight_q && !kill_q && !redir;
    pop       = run && not_empty && !bus.stall && !bus.issue_nop && !redir;

    state_d       = RUN;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    kill_d        = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (!run) begin
      fetch_pc_d = RESET_PC;
    end else if (redir) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
      kill_d     = inflight_q;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
      inflight_d = req;
      if (req) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    if (push) begin
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
      insn_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  // Empty queue presents RESET_PC / zero so bubbles and reset have a defined pc.
  always_comb begin
    bus.imem_req    = req;
    bus.imem_addr   = fetch_pc_q[IMEM_AW+1:2];
    bus.valid       = run && (not_empty || bus.issue_nop);
    bus.pc_out      = not_empty ? pc_mem[rd_ptr_q] : RESET_PC;
    bus.instruction = (run && bus.issue_nop) ? NOP_INSN
                    : (not_empty ? insn_mem[rd_ptr_q] : '0);
  end

endmodule

// File: tb/tb_ifetch_pq.sv
// Random-stimulus bench for ifetch_pq: two instances (DEPTH=4/RESET_PC=0 and DEPTH=2/RESET_PC=0xFFFFFFF8)
// compared each cycle against a queue-based reference model.
module tb_ifetch_pq;
  localparam int          XLEN  = 32;
  localparam int          AW    = 9;
  localparam logic [31:0] RPC_A = 32'h0;
  localparam logic [31:0] RPC_B = 32'hFFFFFFF8;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          NCYC  = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  ifetch_pq_if #(.XLEN(XLEN), .IMEM_AW(AW)) bus_a ();
  ifetch_pq_if #(.XLEN(XLEN), .IMEM_AW(AW)) bus_b ();

  ifetch_pq #(.XLEN(XLEN), .DEPTH(4), .IMEM_AW(AW), .RESET_PC(RPC_A), .NOP_INSN(NOP))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.master));
  ifetch_pq #(.XLEN(XLEN), .DEPTH(2), .IMEM_AW(AW), .RESET_PC(RPC_B), .NOP_INSN(NOP))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.master));

  logic        stall_i [2];
  logic        redir_i [2];
  logic        nop_i   [2];
  logic [31:0] rpc_i   [2];

  assign bus_a.stall = stall_i[0];  assign bus_b.stall = stall_i[1];
  assign bus_a.redirect = redir_i[0];  assign bus_b.redirect = redir_i[1];
  assign bus_a.issue_nop = nop_i[0];  assign bus_b.issue_nop = nop_i[1];
  assign bus_a.redirect_pc = rpc_i[0];  assign bus_b.redirect_pc = rpc_i[1];

  logic          obs_valid [2];
  logic          obs_req   [2];
  logic [AW-1:0] obs_addr  [2];
  logic [31:0]   obs_pc    [2];
  logic [31:0]   obs_ins   [2];

  assign obs_valid[0] = bus_a.valid;        assign obs_valid[1] = bus_b.valid;
  assign obs_req[0]   = bus_a.imem_req;     assign obs_req[1]   = bus_b.imem_req;
  assign obs_addr[0]  = bus_a.imem_addr;    assign obs_addr[1]  = bus_b.imem_addr;
  assign obs_pc[0]    = bus_a.pc_out;       assign obs_pc[1]    = bus_b.pc_out;
  assign obs_ins[0]   = bus_a.instruction;  assign obs_ins[1]   = bus_b.instruction;

  // Memory word n holds n; data is only meaningful the cycle after a request.
  always @(posedge clk) begin
    bus_a.imem_rdata <= bus_a.imem_req ? 32'(bus_a.imem_addr) : $urandom;
    bus_b.imem_rdata <= bus_b.imem_req ? 32'(bus_b.imem_addr) : $urandom;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] insn; } ent_t;
  typedef struct { logic run; logic [31:0] fpc; logic infl; logic [31:0] ipc; logic kill; } mstate_t;

  ent_t    qa[$];
  ent_t    qb[$];
  mstate_t ms [2];
  int      edges_rel [2];
  logic    seen_valid [2];
  int      seq_n [2];

  function automatic string nm(input int i);
    return (i == 0) ? "A" : "B";
  endfunction
  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic logic [31:0] rpc_of(input int i);
    return (i == 0) ? RPC_A : RPC_B;
  endfunction
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc >> 2) & 32'((1 << AW) - 1);
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? qa.size() : qb.size();
  endfunction
  function automatic ent_t q_head(input int i);
    return (i == 0) ? qa[0] : qb[0];
  endfunction
  task automatic q_pop(input int i);
    if (i == 0) void'(qa.pop_front()); else void'(qb.pop_front());
  endtask
  task automatic q_push(input int i, input ent_t e);
    if (i == 0) qa.push_back(e); else qb.push_back(e);
  endtask
  task automatic q_clear(input int i);
    if (i == 0) qa.delete(); else qb.delete();
  endtask

  task automatic model_reset(input int i);
    q_clear(i);
    ms[i].run = 1'b0; ms[i].fpc = rpc_of(i); ms[i].infl = 1'b0;
    ms[i].ipc = '0; ms[i].kill = 1'b0;
    edges_rel[i] = 0; seen_valid[i] = 1'b0; seq_n[i] = 0;
  endtask

  task automatic model_edge(input int i);
    logic req, push, pop;
    ent_t e;
    edges_rel[i]++;
    if (!ms[i].run) begin
      ms[i].run = 1'b1;
      ms[i].fpc = rpc_of(i);
      return;
    end
    req  = (q_size(i) + int'(ms[i].infl) < depth_of(i)) && !redir_i[i];
    push = ms[i].infl && !ms[i].kill && !redir_i[i];
    pop  = (q_size(i) > 0) && !stall_i[i] && !nop_i[i] && !redir_i[i];
    if (redir_i[i]) begin
      q_clear(i);
      ms[i].fpc  = {rpc_i[i][31:2], 2'b00};
      ms[i].kill = ms[i].infl;
      ms[i].infl = 1'b0;
    end else begin
      if (pop) q_pop(i);
      if (push) begin
        e.pc = ms[i].ipc; e.insn = mem_word(ms[i].ipc);
        q_push(i, e);
      end
      ms[i].kill = 1'b0;
      ms[i].infl = req;
      if (req) begin
        ms[i].ipc = ms[i].fpc;
        ms[i].fpc = ms[i].fpc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs(input int i, input logic clean);
    ent_t  h;
    int    sz;
    logic  e_valid, e_req;
    logic [31:0] e_ins;
    sz = q_size(i);
    if (sz > 0) h = q_head(i);
    else begin h.pc = rpc_of(i); h.insn = '0; end
    e_valid = ms[i].run && (sz > 0 || nop_i[i]);
    e_req   = ms[i].run && (sz + int'(ms[i].infl) < depth_of(i)) && !redir_i[i];
    e_ins   = (ms[i].run && nop_i[i]) ? NOP : h.insn;
    chk({nm(i), ".valid"}, 32'(obs_valid[i]), 32'(e_valid));
    chk({nm(i), ".imem_req"}, 32'(obs_req[i]), 32'(e_req));
    chk({nm(i), ".imem_addr"}, 32'(obs_addr[i]), mem_word(ms[i].fpc));
    chk({nm(i), ".pc_out"}, obs_pc[i], h.pc);
    chk({nm(i), ".instruction"}, obs_ins[i], e_ins);
    // Clean start after reset: fixed latency and a linear pc/word sequence.
    if (clean && obs_valid[i] === 1'b1) begin
      if (!seen_valid[i]) begin
        chk({nm(i), ".boot_latency"}, 32'(edges_rel[i]), 32'd3);
        seen_valid[i] = 1'b1;
      end
      if (seq_n[i] < 3) begin
        chk({nm(i), ".seq_pc"}, obs_pc[i], rpc_of(i) + 32'(4 * seq_n[i]));
        chk({nm(i), ".seq_insn"}, obs_ins[i], mem_word(rpc_of(i) + 32'(4 * seq_n[i])));
        seq_n[i]++;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic clean;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall_i[i] = 1'b0; redir_i[i] = 1'b0; nop_i[i] = 1'b0; rpc_i[i] = '0;
      model_reset(i);
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      reset = (c < 3) || (c >= 1000 && c < 1002);
      clean = (c >= 3 && c < 40) || (c >= 1002 && c < 1040);
      for (int i = 0; i < 2; i++) begin
        if (reset) model_reset(i);
        if (reset || clean) begin
          stall_i[i] = 1'b0; redir_i[i] = 1'b0; nop_i[i] = 1'b0; rpc_i[i] = '0;
        end else begin
          stall_i[i] = ($urandom_range(0, 99) < 30) || (c >= 300 && c < 312);
          redir_i[i] = ($urandom_range(0, 99) < 5);
          nop_i[i]   = ($urandom_range(0, 99) < 10);
          rpc_i[i]   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 31)))
                                                   : $urandom;
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        check_outputs(i, clean);
        if (c == 39 || c == 1039) chk({nm(i), ".seen_valid"}, 32'(seen_valid[i]), 32'd1);
      end
      @(posedge clk);
      if (!reset) begin
        for (int i = 0; i < 2; i++) model_edge(i);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
